// File: rtl/seq_mult_pkg.sv
// Shared types and constants for the sequential shift-add multiplier controller.
package seq_mult_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : seq_mult_pkg

// File: rtl/mult_cell.sv
// 1-bit multiplier cell: product of one multiplicand bit and one multiplier bit.
module mult_cell (
  input  logic i_a,
  input  logic i_b,
  output logic o_p
);

  assign o_p = i_a & i_b;

endmodule : mult_cell

// File: rtl/pp_row.sv
// Combinational partial-product row built from one mult_cell per multiplicand bit.
module pp_row #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_mcand,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_pp
);

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    mult_cell u_cell (
      .i_a (i_mcand[g]),
      .i_b (i_bit),
      .o_p (o_pp[g])
    );
  end

endmodule : pp_row

// File: rtl/seq_mult_ctrl.sv
// Sequential shift-add multiplier controller, one multiplier bit per RUN cycle.
// Optional macro SEQ_MULT_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are zero.
//
// state   | meaning
// IDLE    | waiting for start; prod holds the last result
// RUN     | one shift-add step per edge; busy=1
// DONE    | single-cycle done pulse; start here chains directly into RUN
module seq_mult_ctrl
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [PW-1:0]    r_mcand;
  logic [PW-1:0]    r_acc;
  logic [PW-1:0]    r_prod;
  logic [WIDTH-1:0] r_mplier;
  logic [CW-1:0]    r_cnt;

  logic [PW-1:0]    w_pp;
  logic [PW-1:0]    w_acc_sum;
  logic [WIDTH-1:0] w_mplier_shr;
  logic             w_load;
  logic             w_step;
  logic             w_last;

  pp_row #(
    .WIDTH (PW)
  ) u_pp_row (
    .i_mcand (r_mcand),
    .i_bit   (r_mplier[0]),
    .o_pp    (w_pp)
  );

  assign w_acc_sum    = r_acc + w_pp;
  assign w_mplier_shr = r_mplier >> 1;
  assign w_load       = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_step       = (r_state == ST_RUN);

`ifdef SEQ_MULT_EARLY_TERM_EN
  assign w_last = (r_cnt == LAST_STEP) || (w_mplier_shr == '0);
`else
  assign w_last = (r_cnt == LAST_STEP);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = start ? ST_RUN : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // prod is only written on the RUN-to-DONE edge, so it survives the next operation's RUN phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_prod   <= '0;
    end else if (w_load) begin
      r_mcand  <= PW'(a);
      r_mplier <= b;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (w_step) begin
      r_acc    <= w_acc_sum;
      r_mcand  <= r_mcand << 1;
      r_mplier <= w_mplier_shr;
      r_cnt    <= r_cnt + 1'b1;
      if (w_last) r_prod <= w_acc_sum;
    end
  end

  assign prod = r_prod;

endmodule : seq_mult_ctrl

// File: tb/tb_seq_mult_ctrl.sv
// Self-checking bench for seq_mult_ctrl (WIDTH=8) against an arithmetic reference model.
module tb_seq_mult_ctrl;

  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] prod;

  int n_checks = 0;
  int n_fail   = 0;

  seq_mult_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .prod  (prod)
  );

  always #5 clk = ~clk;

  // Edges from start (accepting edge = 1) until done is seen.
  function automatic int exp_lat(input logic [W-1:0] mb);
    int steps;
    steps = W;
`ifdef SEQ_MULT_EARLY_TERM_EN
    steps = 1;
    for (int i = 0; i < W; i++) if (mb[i]) steps = i + 1;
`endif
    return steps + 1;
  endfunction

  function automatic logic [2*W-1:0] exp_prod(input logic [W-1:0] ma, input logic [W-1:0] mb);
    return {{W{1'b0}}, ma} * {{W{1'b0}}, mb};
  endfunction

  // Launch one multiply and count edges until done; lat=-1 on timeout.
  task automatic start_and_wait(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                output int lat, output int busy_cyc);
    @(negedge clk);
    start = 1'b1; a = ia; b = ib;
    lat = 0; busy_cyc = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) start = 1'b0;
      if (busy) busy_cyc++;
      if (done) break;
    end
    if (!done) lat = -1;
  endtask

  task automatic test_reset();
    #12;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%0b exp=0", done); end
    n_checks++; if (prod !== '0) begin n_fail++; $display("FAIL reset_prod got=%0d exp=0", prod); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat, bc;
    start_and_wait(8'd13, 8'd11, lat, bc);
    n_checks++; if (lat !== exp_lat(8'd11)) begin n_fail++; $display("FAIL basic_lat got=%0d exp=%0d", lat, exp_lat(8'd11)); end
    n_checks++; if (bc !== exp_lat(8'd11) - 1) begin n_fail++; $display("FAIL basic_busy got=%0d exp=%0d", bc, exp_lat(8'd11) - 1); end
    n_checks++; if (prod !== 16'd143) begin n_fail++; $display("FAIL basic_prod got=%0d exp=143", prod); end
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse got=%0b exp=0", done); end
  endtask

  task automatic test_corners();
    int lat, bc;
    start_and_wait(8'd255, 8'd255, lat, bc);
    n_checks++; if (prod !== 16'd65025) begin n_fail++; $display("FAIL max_prod got=%0d exp=65025", prod); end
    n_checks++; if (lat !== exp_lat(8'd255)) begin n_fail++; $display("FAIL max_lat got=%0d exp=%0d", lat, exp_lat(8'd255)); end
    start_and_wait(8'd0, 8'd0, lat, bc);
    n_checks++; if (prod !== 16'd0) begin n_fail++; $display("FAIL zero_prod got=%0d exp=0", prod); end
    n_checks++; if (lat !== exp_lat(8'd0)) begin n_fail++; $display("FAIL zero_lat got=%0d exp=%0d", lat, exp_lat(8'd0)); end
  endtask

  task automatic test_random();
    int lat, bc;
    logic [W-1:0] ra, rb;
    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom_range(255, 0));
      rb = 8'($urandom_range(255, 0));
      start_and_wait(ra, rb, lat, bc);
      n_checks++;
      if (prod !== exp_prod(ra, rb)) begin
        n_fail++; $display("FAIL rand_prod %0d*%0d got=%0d exp=%0d", ra, rb, prod, exp_prod(ra, rb));
      end
      n_checks++;
      if (lat !== exp_lat(rb)) begin
        n_fail++; $display("FAIL rand_lat b=%0d got=%0d exp=%0d", rb, lat, exp_lat(rb));
      end
    end
  endtask

  task automatic test_start_ignored();
    int n, first_done, pulses;
    @(negedge clk);
    start = 1'b1; a = 8'd13; b = 8'd11;
    n = 0; first_done = -1; pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      n++;
      start = 1'b0;
      if (n == 3) begin
        @(negedge clk);
        start = 1'b1; a = 8'd3; b = 8'd3;
      end
      if (done) begin
        pulses++;
        if (first_done < 0) first_done = n;
      end
    end
    n_checks++; if (first_done !== exp_lat(8'd11)) begin n_fail++; $display("FAIL ign_lat got=%0d exp=%0d", first_done, exp_lat(8'd11)); end
    n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL ign_pulses got=%0d exp=1", pulses); end
    n_checks++; if (prod !== 16'd143) begin n_fail++; $display("FAIL ign_prod got=%0d exp=143", prod); end
  endtask

  task automatic test_reset_abort();
    int lat, bc, pulses;
    @(negedge clk);
    start = 1'b1; a = 8'd13; b = 8'd11;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%0b exp=0", busy); end
    n_checks++; if (prod !== '0) begin n_fail++; $display("FAIL abort_prod got=%0d exp=0", prod); end
    @(negedge clk); rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL abort_no_done got=%0d exp=0", pulses); end
    start_and_wait(8'd7, 8'd6, lat, bc);
    n_checks++; if (prod !== 16'd42) begin n_fail++; $display("FAIL abort_next_prod got=%0d exp=42", prod); end
    n_checks++; if (lat !== exp_lat(8'd6)) begin n_fail++; $display("FAIL abort_next_lat got=%0d exp=%0d", lat, exp_lat(8'd6)); end
  endtask

  task automatic test_back_to_back();
    int n, d1, d2, idle_cyc;
    logic [2*W-1:0] p1, p2;
    @(negedge clk);
    start = 1'b1; a = 8'd5; b = 8'd5;
    n = 0; d1 = -1; d2 = -1; idle_cyc = 0; p1 = '0; p2 = '0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin a = 8'd9; b = 8'd9; end
      if (!busy && !done) idle_cyc++;
      if (done) begin
        if (d1 < 0) begin d1 = n; p1 = prod; end
        else begin d2 = n; p2 = prod; start = 1'b0; break; end
      end
    end
    start = 1'b0;
    n_checks++; if (d1 !== exp_lat(8'd5)) begin n_fail++; $display("FAIL b2b_first got=%0d exp=%0d", d1, exp_lat(8'd5)); end
    n_checks++; if (p1 !== 16'd25) begin n_fail++; $display("FAIL b2b_prod1 got=%0d exp=25", p1); end
    n_checks++; if (d2 - d1 !== exp_lat(8'd9)) begin n_fail++; $display("FAIL b2b_gap got=%0d exp=%0d", d2 - d1, exp_lat(8'd9)); end
    n_checks++; if (p2 !== 16'd81) begin n_fail++; $display("FAIL b2b_prod2 got=%0d exp=81", p2); end
    n_checks++; if (idle_cyc !== 0) begin n_fail++; $display("FAIL b2b_idle got=%0d exp=0", idle_cyc); end
  endtask

`ifdef SEQ_MULT_EARLY_TERM_EN
  task automatic test_early_term();
    int lat, bc;
    start_and_wait(8'd200, 8'd1, lat, bc);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL et_b1_lat got=%0d exp=2", lat); end
    n_checks++; if (prod !== 16'd200) begin n_fail++; $display("FAIL et_b1_prod got=%0d exp=200", prod); end
    start_and_wait(8'd2, 8'h80, lat, bc);
    n_checks++; if (lat !== 9) begin n_fail++; $display("FAIL et_b80_lat got=%0d exp=9", lat); end
    n_checks++; if (prod !== 16'd256) begin n_fail++; $display("FAIL et_b80_prod got=%0d exp=256", prod); end
  endtask
`endif

  initial begin
    clk = 1'b0; rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    test_reset();
    test_basic();
    test_corners();
    test_random();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
`ifdef SEQ_MULT_EARLY_TERM_EN
    test_early_term();
`endif
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_seq_mult_ctrl
